uart_rx: RTL and testbench

UART receiver for the photo-frame serial link. It recovers bytes from the asynchronous serial line i_uart_rx using a free-running baud counter and mid-bit sampling. Each received word is presented on a parallel output with a one-cycle valid strobe plus parity and framing status. It sits between the board serial pin and the byte consumer, for example the BSRAM write logic, and is the receive-side counterpart of the project's UART transmitter, sharing its parameter set and bit format.

---
 rtl/uart_rx.sv | 112 +++++++++++
 tb/tb_uart_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-FF input synchroniser, free-running baud counter, mid-bit sampling.
// Each received word is presented with a one-cycle valid strobe plus parity and framing status.
module uart_rx #(
    parameter int CLK_FRE     = 50,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_ON   = 0,
    parameter int PARITY_TYPE = 0,
    parameter int BAUD_RATE   = 9600
) (
    input  logic                  i_clk_sys,
    input  logic                  i_rst_n,
    input  logic                  i_uart_rx,
    output logic [DATA_WIDTH-1:0] o_data_rx,
    output logic                  o_data_valid,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_busy
);

    localparam int          CYCLE  = CLK_FRE * 1000000 / BAUD_RATE;
    localparam logic [15:0] SAMPLE = 16'(CYCLE / 2 - 1);
    localparam logic [15:0] LAST   = 16'(CYCLE - 1);
    localparam int          BW     = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_nx;
    logic                  rx_m, rx_s, rx_d;
    logic [15:0]           cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_mis;
    logic                  sample, bound;

    assign sample = (cnt == SAMPLE);
    assign bound  = (cnt == LAST);

    // rx_d is the edge-detect register; resetting it high avoids a false start edge.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= i_uart_rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (rx_d && !rx_s) state_nx = START;
            START: begin
                if (sample && rx_s) state_nx = IDLE;
                else if (bound)     state_nx = DATA;
            end
            DATA: begin
                if (bound && bit_cnt == BW'(DATA_WIDTH))
                    state_nx = (PARITY_ON != 0) ? PARITY : STOP;
            end
            PARITY: if (bound)  state_nx = STOP;
            STOP:   if (sample) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Stop is left at mid-bit so a back-to-back start edge is never missed.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt          <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            par_mis      <= 1'b0;
            o_data_rx    <= '0;
            o_data_valid <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            o_busy       <= (state_nx != IDLE);

            if (state == IDLE || state_nx == IDLE) cnt <= '0;
            else if (bound)                        cnt <= '0;
            else                                   cnt <= cnt + 16'd1;

            if (state != DATA) bit_cnt <= '0;
            else if (sample) begin
                bit_cnt <= bit_cnt + BW'(1);
                shift   <= (shift >> 1) | (DATA_WIDTH'(rx_s) << (DATA_WIDTH - 1));
            end

            if (state == PARITY && sample)
                par_mis <= rx_s != ((PARITY_TYPE != 0) ? ^shift : ~^shift);

            if (state == STOP && sample) begin
                o_data_rx    <= shift;
                o_frame_err  <= ~rx_s;
                o_parity_err <= (PARITY_ON != 0) ? par_mis : 1'b0;
                o_data_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: two instances (no parity / XOR parity) driven with directed and random frames,
// checked every cycle against a frame-level model (expected strobe cycle, busy window, held outputs).
module tb_uart_rx;

    localparam int C = 16;  // 2 MHz / 125000 baud

    typedef struct {
        int         w;
        int         t0;
        int         t_end;
        bit         strobe;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] line = 2'b11;
    wire  [1:0][7:0] dat;
    wire  [1:0] dv, pe, fe, bz;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    rec_t q[$];
    logic [7:0] ld[2];
    logic       lpe[2], lfe[2];
    int         nstrobe[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_rx #(.CLK_FRE(2), .DATA_WIDTH(8), .PARITY_ON(0), .PARITY_TYPE(0), .BAUD_RATE(125000)) dut_a (
        .i_clk_sys(clk), .i_rst_n(rst_n), .i_uart_rx(line[0]),
        .o_data_rx(dat[0]), .o_data_valid(dv[0]), .o_parity_err(pe[0]),
        .o_frame_err(fe[0]), .o_busy(bz[0]));

    uart_rx #(.CLK_FRE(2), .DATA_WIDTH(8), .PARITY_ON(1), .PARITY_TYPE(1), .BAUD_RATE(125000)) dut_b (
        .i_clk_sys(clk), .i_rst_n(rst_n), .i_uart_rx(line[1]),
        .o_data_rx(dat[1]), .o_data_valid(dv[1]), .o_parity_err(pe[1]),
        .o_frame_err(fe[1]), .o_busy(bz[1]));

    task automatic chk(input string name, input int w, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors < 30)
                $display("FAIL %s[dut%0d] at cycle %0d: got %0h, expected %0h", name, w, cyc, act, exp);
        end
    endtask

    // Model: outputs hold the last delivered frame; strobe lands at a fixed cycle after the start edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int w = 0; w < 2; w++) begin
                bit ev, eb;
                ev = 1'b0;
                eb = 1'b0;
                if (q.size() > 0 && q[0].w == w) begin
                    if (cyc >= q[0].t0 + 3 && cyc < q[0].t_end) eb = 1'b1;
                    if (cyc == q[0].t_end && q[0].strobe) begin
                        ev = 1'b1;
                        ld[w]  = q[0].d;
                        lpe[w] = q[0].pe;
                        lfe[w] = q[0].fe;
                    end
                end
                if (dv[w]) nstrobe[w]++;
                chk("valid",  w, 32'(dv[w]),  32'(ev));
                chk("busy",   w, 32'(bz[w]),  32'(eb));
                chk("data",   w, 32'(dat[w]), 32'(ld[w]));
                chk("parity", w, 32'(pe[w]),  32'(lpe[w]));
                chk("frame",  w, 32'(fe[w]),  32'(lfe[w]));
            end
            if (q.size() > 0 && cyc >= q[0].t_end) void'(q.pop_front());
        end
    end

    task automatic idle(input int w, input int g);
        line[w] = 1'b1;
        repeat (g) @(negedge clk);
    endtask

    // dut1 checks parity = XOR of data bits; dut0 has no parity bit.
    task automatic send(input int w, input logic [7:0] d, input logic pb, input logic sb);
        logic [10:0] b;
        int          n;
        rec_t        r;
        n = (w == 1) ? 11 : 10;
        b = (w == 1) ? {sb, pb, d, 1'b0} : {1'b1, sb, d, 1'b0};
        r.w = w; r.t0 = cyc; r.t_end = cyc + 3 + (n - 1) * C + C / 2; r.strobe = 1'b1;
        r.d = d; r.pe = (w == 1) ? (pb != ^d) : 1'b0; r.fe = ~sb;
        q.push_back(r);
        for (int i = 0; i < n; i++) begin
            line[w] = b[i];
            repeat (C) @(negedge clk);
        end
    endtask

    task automatic glitch(input int w, input int len);
        rec_t r;
        r.w = w; r.t0 = cyc; r.t_end = cyc + 3 + C / 2; r.strobe = 1'b0;
        r.d = 8'h00; r.pe = 1'b0; r.fe = 1'b0;
        q.push_back(r);
        line[w] = 1'b0;
        repeat (len) @(negedge clk);
        line[w] = 1'b1;
    endtask

    task automatic clear_model();
        q.delete();
        for (int w = 0; w < 2; w++) begin
            ld[w] = 8'h00; lpe[w] = 1'b0; lfe[w] = 1'b0;
        end
    endtask

    initial begin
        int s0;
        logic [7:0] pat;
        clear_model();
        nstrobe[0] = 0; nstrobe[1] = 0;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            chk("rst_data",  w, 32'(dat[w]), 0);
            chk("rst_valid", w, 32'(dv[w]),  0);
            chk("rst_busy",  w, 32'(bz[w]),  0);
            chk("rst_perr",  w, 32'(pe[w]),  0);
            chk("rst_ferr",  w, 32'(fe[w]),  0);
        end
        rst_n = 1'b1;
        idle(0, 4);

        send(0, 8'hA5, 1'b0, 1'b1);
        idle(0, 2 * C);
        chk("a5_data", 0, 32'(dat[0]), 32'hA5);
        chk("a5_ferr", 0, 32'(fe[0]), 0);
        chk("a5_busy", 0, 32'(bz[0]), 0);
        chk("a5_cnt",  0, nstrobe[0], 1);

        glitch(0, C / 4);
        idle(0, 2 * C);
        chk("glitch_hold", 0, 32'(dat[0]), 32'hA5);
        chk("glitch_cnt",  0, nstrobe[0], 1);

        // 0x03 has XOR 0: parity bit 0 matches, parity bit 1 is a mismatch.
        send(1, 8'h03, 1'b0, 1'b1);
        idle(1, 2 * C);
        chk("par0_err",  1, 32'(pe[1]), 0);
        chk("par0_data", 1, 32'(dat[1]), 32'h03);
        send(1, 8'h03, 1'b1, 1'b1);
        idle(1, 2 * C);
        chk("par1_err",  1, 32'(pe[1]), 1);
        chk("par1_data", 1, 32'(dat[1]), 32'h03);

        s0 = nstrobe[0];
        send(0, 8'h55, 1'b0, 1'b0);
        repeat (20 * C) @(negedge clk);
        chk("break_cnt",  0, nstrobe[0] - s0, 1);
        chk("break_ferr", 0, 32'(fe[0]), 1);
        chk("break_data", 0, 32'(dat[0]), 32'h55);
        idle(0, 2 * C);
        send(0, 8'h3C, 1'b0, 1'b1);
        idle(0, 2 * C);
        chk("after_break_data", 0, 32'(dat[0]), 32'h3C);
        chk("after_break_ferr", 0, 32'(fe[0]), 0);

        s0 = nstrobe[0];
        send(0, 8'h00, 1'b0, 1'b1);
        send(0, 8'hFF, 1'b0, 1'b1);
        idle(0, 2 * C);
        chk("b2b_cnt",  0, nstrobe[0] - s0, 2);
        chk("b2b_data", 0, 32'(dat[0]), 32'hFF);

        for (int k = 0; k < 40; k++) begin
            int   w;
            logic sb;
            w  = int'($urandom_range(0, 1));
            sb = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) begin
                glitch(w, int'($urandom_range(1, C / 2)));
                idle(w, C);
            end
            send(w, 8'($urandom), 1'($urandom), sb);
            if (!sb) idle(w, C + int'($urandom_range(0, C)));
            else if ($urandom_range(0, 2) != 0) idle(w, int'($urandom_range(1, 3 * C)));
        end
        idle(0, 2 * C);
        idle(1, 2 * C);

        send(0, 8'hC3, 1'b0, 1'b1);
        idle(0, 2 * C);
        s0 = nstrobe[0];
        begin
            rec_t r;
            r.w = 0; r.t0 = cyc; r.t_end = cyc + 3 + 9 * C + C / 2; r.strobe = 1'b1;
            r.d = 8'h81; r.pe = 1'b0; r.fe = 1'b0;
            q.push_back(r);
        end
        pat = 8'h81;
        line[0] = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            line[0] = pat[i];
            repeat (C) @(negedge clk);
        end
        line[0] = pat[4];
        repeat (C / 2) @(negedge clk);
        #2 rst_n = 1'b0;
        clear_model();
        #1;
        chk("mid_rst_data",  0, 32'(dat[0]), 0);
        chk("mid_rst_busy",  0, 32'(bz[0]),  0);
        chk("mid_rst_valid", 0, 32'(dv[0]),  0);
        line[0] = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        idle(0, 4);
        send(0, 8'h7E, 1'b0, 1'b1);
        idle(0, 2 * C);
        chk("post_rst_data", 0, 32'(dat[0]), 32'h7E);
        chk("post_rst_cnt",  0, nstrobe[0] - s0, 1);

        for (int i = 0; i < 2000 && q.size() > 0; i++) @(negedge clk);
        chk("drain", 0, q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
